// File: rtl/bus_arbiter_if.sv
// Fabric bundle between the requesting masters, the round-robin arbiter and the shared register slave.
// Handshake: a master holds m_valid (and its command) until it sees its one-cycle m_ready pulse; the slave completes an s_valid command by raising s_ready for one cycle.
interface bus_if #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 16,
    parameter int DW          = 32
);
    logic [NUM_MASTERS-1:0]    m_valid;
    logic [NUM_MASTERS-1:0]    m_read;
    logic [NUM_MASTERS-1:0]    m_write;
    logic [NUM_MASTERS*AW-1:0] m_addr;
    logic [NUM_MASTERS*DW-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]    m_ready;
    logic [NUM_MASTERS-1:0]    m_err;
    logic [DW-1:0]             m_rdata;
    logic [NUM_MASTERS-1:0]    grant;
    logic                      s_valid;
    logic                      s_read;
    logic                      s_write;
    logic [AW-1:0]             s_addr;
    logic [DW-1:0]             s_wdata;
    logic [DW-1:0]             s_rdata;
    logic                      s_ready;

    // slave: the arbiter itself; master: the requesters together with the register slave
    modport slave (
        input  m_valid, m_read, m_write, m_addr, m_wdata, s_rdata, s_ready,
        output m_ready, m_err, m_rdata, grant, s_valid, s_read, s_write, s_addr, s_wdata
    );
    modport master (
        output m_valid, m_read, m_write, m_addr, m_wdata, s_rdata, s_ready,
        input  m_ready, m_err, m_rdata, grant, s_valid, s_read, s_write, s_addr, s_wdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one register slave between NUM_MASTERS requesters.
// One grant covers a whole transaction; out-of-region or malformed commands and slave timeouts end in an error response.
module bus_arbiter #(
    parameter int         NUM_MASTERS  = 4,
    parameter int         AW           = 16,
    parameter int         DW           = 32,
    parameter logic [3:0] SLAVE_REGION = 4'h0,
    parameter int         TIMEOUT      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    bus_if.slave       bus,
    output logic [1:0] dbg_state_o
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   hit_q, hit_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] m_ready_q, m_ready_d;
    logic [NUM_MASTERS-1:0] m_err_q, m_err_d;
    logic [DW-1:0]          m_rdata_q, m_rdata_d;

    logic                   found;
    logic [IW-1:0]          win_idx;
    logic [IW:0]            cand;
    logic [AW-1:0]          win_addr;
    logic                   win_rd;
    logic                   win_wr;
    logic                   s_valid_w;

    // Rotating priority search: first requester at or after rr_ptr wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_MASTERS)) cand = cand - (IW+1)'(NUM_MASTERS);
            if (!found && bus.m_valid[cand[IW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    assign win_addr = bus.m_addr[int'(win_idx)*AW +: AW];
    assign win_rd   = bus.m_read[win_idx];
    assign win_wr   = bus.m_write[win_idx];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        hit_d     = hit_q;
        cnt_d     = cnt_q;
        m_ready_d = '0;
        m_err_d   = '0;
        m_rdata_d = m_rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx;
                    gidx_d  = win_idx;
                    addr_d  = win_addr;
                    wdata_d = bus.m_wdata[int'(win_idx)*DW +: DW];
                    rd_d    = win_rd;
                    wr_d    = win_wr;
                    // A command that is neither a pure read nor a pure write never reaches the slave.
                    hit_d   = (win_rd ^ win_wr) && (win_addr[AW-1:AW-4] == SLAVE_REGION);
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!hit_q) begin
                    m_ready_d = grant_q;
                    m_err_d   = grant_q;
                    m_rdata_d = '0;
                    state_d   = RESP;
                end else if (bus.s_ready) begin
                    m_ready_d = grant_q;
                    m_rdata_d = rd_q ? bus.s_rdata : '0;
                    state_d   = RESP;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    m_ready_d = grant_q;
                    m_err_d   = grant_q;
                    m_rdata_d = '0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rr_ptr_d = (gidx_q == IW'(NUM_MASTERS-1)) ? '0 : gidx_q + 1'b1;
                grant_d  = '0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            hit_q     <= 1'b0;
            cnt_q     <= '0;
            m_ready_q <= '0;
            m_err_q   <= '0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            hit_q     <= hit_d;
            cnt_q     <= cnt_d;
            m_ready_q <= m_ready_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign s_valid_w   = (state_q == ACCESS) && hit_q;
    assign bus.s_valid = s_valid_w;
    assign bus.s_read  = s_valid_w & rd_q;
    assign bus.s_write = s_valid_w & wr_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.grant   = grant_q;
    assign bus.m_ready = m_ready_q;
    assign bus.m_err   = m_err_q;
    assign bus.m_rdata = m_rdata_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single transactions, decode miss, illegal command, timeout,
// round-robin order from reset and asynchronous reset in the middle of an access.
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    bus_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bif();

    bus_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .SLAVE_REGION(4'h0), .TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bif),
        .dbg_state_o (dbg_state)
    );

    int             n_checks;
    int             n_fail;
    logic [N-1:0]   exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bif.m_valid = '0;
        bif.m_read  = '0;
        bif.m_write = '0;
        bif.m_addr  = '0;
        bif.m_wdata = '0;
        bif.s_rdata = '0;
        bif.s_ready = 1'b0;
    endtask

    // Called at a negedge with the arbiter idle; the slave raises s_ready after wait_cyc stalled cycles.
    task automatic run_txn(input int idx, input bit rd, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int wait_cyc, input logic [DW-1:0] srd,
                           input bit exp_err, input int exp_lat, input int exp_sv,
                           input logic [DW-1:0] exp_rd, input bit mutate);
        int cyc;
        int acc;
        bit done;
        bif.m_valid[idx]             = 1'b1;
        bif.m_read[idx]              = rd;
        bif.m_write[idx]             = wr;
        bif.m_addr[idx*AW +: AW]     = addr;
        bif.m_wdata[idx*DW +: DW]    = wd;
        bif.s_rdata                  = srd;
        bif.s_ready                  = 1'b0;
        cyc  = 0;
        acc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("grant", bif.grant, N'(1) << idx);
                check("state_access", dbg_state, 2'd1);
                if (mutate) begin
                    bif.m_addr[idx*AW +: AW]  = ~addr;
                    bif.m_wdata[idx*DW +: DW] = ~wd;
                    bif.m_valid[idx]          = 1'b0;
                end
            end
            if (bif.s_valid) begin
                check("s_addr", bif.s_addr, addr);
                check("s_read", bif.s_read, rd);
                check("s_write", bif.s_write, wr);
                if (wr) check("s_wdata", bif.s_wdata, wd);
            end
            if (bif.m_ready != '0) begin
                done = 1'b1;
                check("m_ready", bif.m_ready, N'(1) << idx);
                check("m_err", bif.m_err, exp_err ? (N'(1) << idx) : N'(0));
                check("m_rdata", bif.m_rdata, exp_rd);
                check("latency", cyc, exp_lat);
                check("access_cycles", acc, exp_sv);
                bif.m_valid[idx] = 1'b0;
                bif.s_ready      = 1'b0;
            end else begin
                bif.s_ready = bif.s_valid && (acc == wait_cyc);
                if (bif.s_valid) acc++;
            end
        end
        if (!done) check("m_ready_timeout", 0, 1);
        @(negedge clk);
        check("m_ready_pulse", bif.m_ready, 0);
        check("grant_idle", bif.grant, 0);
        check("state_idle", dbg_state, 2'd0);
    endtask

    initial begin
        int cyc;
        logic [N-1:0] e;
        n_checks = 0;
        n_fail   = 0;
        idle_bus();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", bif.grant, 0);
        check("rst_m_ready", bif.m_ready, 0);
        check("rst_m_err", bif.m_err, 0);
        check("rst_m_rdata", bif.m_rdata, 0);
        check("rst_s_valid", bif.s_valid, 0);
        check("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;

        // Round-robin with every master requesting continuously from reset.
        for (int i = 0; i < N; i++) begin
            bif.m_valid[i]          = 1'b1;
            bif.m_write[i]          = 1'b1;
            bif.m_addr[i*AW +: AW]  = 16'h0020 + 16'(i);
            bif.m_wdata[i*DW +: DW] = 32'h1000 + 32'(i);
        end
        bif.s_ready = 1'b1;
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (bif.m_ready != '0) begin
                e = exp_q.pop_front();
                check("rr_order", bif.m_ready, e);
                check("rr_err", bif.m_err, 0);
            end
        end
        check("rr_remaining", exp_q.size(), 0);
        idle_bus();
        @(negedge clk);
        check("rr_state_idle", dbg_state, 2'd0);

        run_txn(0, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2, 1, 32'h0, 1'b0);
        run_txn(2, 1'b1, 1'b0, 16'h0010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 5, 4, 32'hDEADBEEF, 1'b1);
        run_txn(1, 1'b0, 1'b1, 16'h1234, 32'h55AA55AA, 0, 32'h0, 1'b1, 2, 0, 32'h0, 1'b0);
        run_txn(2, 1'b1, 1'b1, 16'h0010, 32'h12345678, 0, 32'hCAFEF00D, 1'b1, 2, 0, 32'h0, 1'b0);
        run_txn(2, 1'b0, 1'b0, 16'h0014, 32'h0, 0, 32'hCAFEF00D, 1'b1, 2, 0, 32'h0, 1'b0);
        run_txn(3, 1'b1, 1'b0, 16'h0040, 32'h0, 100, 32'hBAD0BAD0, 1'b1, 17, 16, 32'h0, 1'b0);
        run_txn(0, 1'b0, 1'b1, 16'h0044, 32'hA5A5A5A5, 1, 32'h0, 1'b0, 3, 2, 32'h0, 1'b1);
        run_txn(1, 1'b1, 1'b0, 16'h0FFC, 32'h0, 2, 32'h0BADCAFE, 1'b0, 4, 3, 32'h0BADCAFE, 1'b0);

        // Reset in the middle of a stalled read.
        bif.m_valid[1]         = 1'b1;
        bif.m_read[1]          = 1'b1;
        bif.m_write[1]         = 1'b0;
        bif.m_addr[1*AW +: AW] = 16'h0010;
        bif.s_ready            = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_state", dbg_state, 2'd1);
        check("mid_s_valid", bif.s_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_s_valid", bif.s_valid, 0);
        check("arst_grant", bif.grant, 0);
        check("arst_m_ready", bif.m_ready, 0);
        check("arst_m_rdata", bif.m_rdata, 0);
        check("arst_state", dbg_state, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bif.m_valid              = 4'b0111;
        bif.m_write[0]           = 1'b1;
        bif.m_read[0]            = 1'b0;
        bif.m_addr[0*AW +: AW]   = 16'h0030;
        bif.m_write[2]           = 1'b1;
        bif.m_read[2]            = 1'b0;
        bif.m_addr[2*AW +: AW]   = 16'h0034;
        @(negedge clk);
        check("post_rst_grant", bif.grant, 4'b0001);
        check("post_rst_s_addr", bif.s_addr, 16'h0030);
        bif.s_ready = 1'b1;
        @(negedge clk);
        check("post_rst_m_ready", bif.m_ready, 4'b0001);
        idle_bus();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single slave_reg register slave between NUM_MASTERS master_reg-style requesters on the bus_if fabric.
- Holds one grant for a whole transaction and forwards the granted master's command to the slave port.
- Decodes the slave region (addr[15:12] == SLAVE_REGION); out-of-region accesses complete immediately with an error.
- Aborts with an error if the slave withholds ready for TIMEOUT cycles.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- AW, 16, address width
- DW, 32, data width
- SLAVE_REGION, 4'h0, value of addr[AW-1:AW-4] selecting the slave
- TIMEOUT, 16, maximum cycles in ACCESS waiting for s_ready (≥2)

Ports:
- clk  in  1  bus clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  NUM_MASTERS  per-master request; held high until that master's m_ready
- m_read  in  NUM_MASTERS  per-master read command
- m_write  in  NUM_MASTERS  per-master write command
- m_addr  in  NUM_MASTERS*AW  packed addresses; master i at [i*AW +: AW]
- m_wdata  in  NUM_MASTERS*DW  packed write data
- m_ready  out  NUM_MASTERS  one-hot, one-cycle completion pulse
- m_err  out  NUM_MASTERS  one-cycle error flag, coincident with m_ready
- m_rdata  out  DW  shared read data; valid only with m_ready
- grant  out  NUM_MASTERS  one-hot current owner; 0 when idle
- s_valid  out  1  command valid to slave
- s_read  out  1  forwarded read
- s_write  out  1  forwarded write
- s_addr  out  AW  forwarded address
- s_wdata  out  DW  forwarded write data
- s_rdata  in  DW  slave read data
- s_ready  in  1  slave completion

Behaviour:
- Reset (async assert, sync release): state = IDLE, rr_ptr = 0, grant = 0, m_ready = 0, m_err = 0, m_rdata = 0, s_valid = 0, timeout counter = 0.
- All outputs are registered, or decoded from registered state/grant.
- IDLE:
  - Search m_valid starting at index rr_ptr, wrapping modulo NUM_MASTERS; the first set bit wins.
  - On a winner: latch grant, latch its addr/read/write/wdata, go to ACCESS.
  - Arbitration takes 1 cycle: a request sampled at edge t gives grant and s_valid from t+1.
- ACCESS:
  - s_valid = 1 if the latched address hits SLAVE_REGION, else 0.
  - s_* come from the latched command, so they stay stable even if the master changes inputs.
  - Hit and s_ready: capture s_rdata into m_rdata (read) or 0 (write); m_ready[g] = 1, m_err[g] = 0 next cycle; go to RESP.
  - Miss: with no slave access, m_ready[g] = 1, m_err[g] = 1, m_rdata = 0 next cycle; go to RESP.
  - Timeout counter increments each ACCESS cycle. When it reaches TIMEOUT-1 without s_ready: m_ready[g] = 1, m_err[g] = 1, m_rdata = 0; go to RESP. If s_ready arrives on that same cycle, the normal completion wins.
- RESP:
  - m_ready/m_err are high for exactly this one cycle; s_valid = 0.
  - rr_ptr becomes (g+1) mod NUM_MASTERS; grant clears; counter clears; go to IDLE.
  - The master deasserts m_valid on the cycle after m_ready. The RESP cycle guarantees no re-grant on a stale valid.
- Illegal command (read and write both 1, or both 0):
  - Treated as a miss: error response, no slave access.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 transactions.
- A master dropping m_valid while granted does not abort; the transaction completes normally.
- Reset asserted mid-transaction: everything returns to reset values immediately; s_valid drops asynchronously.
- Transaction latency, request to m_ready:
  - Hit: 2 + slave wait cycles.
  - Miss: 2 cycles.

Test Plan:
- Single write: master 0 writes 0xDEADBEEF to 0x0010, slave ready on first ACCESS cycle -> grant = 0001 at t+1; s_addr = 0x0010, s_wdata = 0xDEADBEEF; m_ready[0] at t+2, m_err[0] = 0.
- Read back: master 2 reads 0x0010, slave returns 0xDEADBEEF after 3 wait cycles -> m_rdata = 0xDEADBEEF with m_ready[2], 5 cycles after request.
- Round-robin: all 4 masters hold valid continuously from reset -> grant order 0,1,2,3,0. No master gets two grants before every other master gets one.
- Decode miss: master 1 accesses 0x1234 -> s_valid never asserts; m_ready[1] = 1, m_err[1] = 1, m_rdata = 0 two cycles after request.
- Timeout: slave holds s_ready = 0 and TIMEOUT = 16 -> m_err[3] with m_ready[3] after 16 ACCESS cycles; next master granted afterwards.
- Reset mid-ACCESS: rst_n pulsed low during a pending read -> s_valid, grant, m_ready all 0 immediately. After release, rr_ptr = 0 and master 0 wins first.
